// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution MAC engine: FSM states,
// derived-size functions and the per-lane bias/round/ReLU/saturate step.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_DRAIN,
        ST_OUT,
        ST_DONE
    } state_t;

    // Post-processing runs at a fixed wide width so one function serves any lane size
    localparam int unsigned PP_W = 64;

    function automatic int unsigned calc_taps(input int unsigned k, input int unsigned chin);
        return k * k * chin;
    endfunction

    function automatic int unsigned calc_groups(input int unsigned chout, input int unsigned dsp);
        return chout / dsp;
    endfunction

    function automatic int unsigned calc_nwin(input int unsigned h, input int unsigned w,
                                              input int unsigned k, input int unsigned s,
                                              input int unsigned p);
        return ((h + 2 * p - k) / s + 1) * ((w + 2 * p - k) / s + 1);
    endfunction

    function automatic int unsigned calc_acc_w(input int unsigned width, input int unsigned taps);
        return 2 * width + $clog2(taps) + 1;
    endfunction

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // acc + bias<<frac, round half-up, then ReLU or signed saturation to width bits
    function automatic logic signed [PP_W-1:0] post_proc(input logic signed [PP_W-1:0] acc,
                                                         input logic signed [PP_W-1:0] bias,
                                                         input int unsigned frac,
                                                         input int unsigned width,
                                                         input logic relu);
        logic signed [PP_W-1:0] r;
        logic signed [PP_W-1:0] max_v;
        logic signed [PP_W-1:0] min_v;
        r = acc + (bias <<< frac);
        if (frac != 0) r = r + (64'sd1 <<< (frac - 1));
        r = r >>> frac;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (relu && (r < 64'sd0)) r = '0;
        else if (r > max_v) r = max_v;
        else if (r < min_v) r = min_v;
        return r;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: registered product, accumulator that loads on the first tap,
// and registered post-processed result.
import conv_pkg::*;

module mac_lane #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FRAC    = 8,
    parameter int unsigned ACC_W   = 42,
    parameter int unsigned RELU_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic             first,
    input  logic [WIDTH-1:0] px,
    input  logic [WIDTH-1:0] wt,
    input  logic [WIDTH-1:0] bias,
    input  logic             load_out,
    output logic [WIDTH-1:0] result
);

    logic signed [2*WIDTH-1:0] prod_q;
    logic                      vld_q;
    logic                      first_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [PP_W-1:0]    pp_c;

    assign pp_c = post_proc(PP_W'(acc_q), PP_W'($signed(bias)), FRAC, WIDTH, 1'(RELU_EN));

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            acc_q   <= '0;
            result  <= '0;
        end else begin
            vld_q   <= issue;
            first_q <= first;
            if (issue) prod_q <= (2*WIDTH)'($signed(px)) * (2*WIDTH)'($signed(wt));
            // First tap of a window/group overwrites stale sums from the previous one
            if (vld_q) acc_q <= first_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
            if (load_out) result <= WIDTH'(pp_c);
        end
    end

endmodule

// File: rtl/conv_mac_engine.sv
// Convolution engine: DSP_NO parallel MAC lanes sequenced per window and
// channel group by a single-clock FSM with valid/ready pixel and result ports.
import conv_pkg::*;

module conv_mac_engine #(
    parameter int unsigned DSP_NO     = 16,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned KERNEL_DIM = 3,
    parameter int unsigned CHIN       = 32,
    parameter int unsigned CHOUT      = 128,
    parameter int unsigned W_IN       = 32,
    parameter int unsigned H_IN       = 32,
    parameter int unsigned STRIDE     = 1,
    parameter int unsigned PAD        = 0,
    parameter int unsigned RELU_EN    = 1,
    localparam int unsigned TAPS   = calc_taps(KERNEL_DIM, CHIN),
    localparam int unsigned GROUPS = calc_groups(CHOUT, DSP_NO),
    localparam int unsigned NWIN   = calc_nwin(H_IN, W_IN, KERNEL_DIM, STRIDE, PAD),
    localparam int unsigned ACC_W  = calc_acc_w(WIDTH, TAPS),
    localparam int unsigned ADDR_W = clog2_min1(GROUPS * TAPS),
    localparam int unsigned GRP_W  = clog2_min1(GROUPS),
    localparam int unsigned TAP_W  = clog2_min1(TAPS),
    localparam int unsigned WIN_W  = clog2_min1(NWIN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    layer_en,
    input  logic [WIDTH-1:0]        px_data,
    input  logic                    px_valid,
    output logic                    px_ready,
    output logic [ADDR_W-1:0]       wt_addr,
    input  logic [DSP_NO*WIDTH-1:0] wt_data,
    input  logic [DSP_NO*WIDTH-1:0] bias_data,
    output logic [GRP_W-1:0]        bias_grp,
    output logic [DSP_NO*WIDTH-1:0] ofm_data,
    output logic                    ofm_valid,
    input  logic                    ofm_ready,
    output logic [GRP_W-1:0]        ofm_grp,
    output logic                    layer_end,
    output logic                    busy
);

    state_t           state, state_n;
    logic [TAP_W-1:0] tap, tap_n;
    logic [GRP_W-1:0] grp, grp_n;
    logic [WIN_W-1:0] win, win_n;
    logic             drain_cnt, drain_n;
    logic             accept_c;
    logic             first_c;
    logic             load_out_c;

    assign accept_c = px_valid && px_ready;
    assign first_c  = (tap == '0);
    assign wt_addr  = ADDR_W'(grp) * ADDR_W'(TAPS) + ADDR_W'(tap);
    assign bias_grp = grp;

    // State, counters and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tap       <= '0;
            grp       <= '0;
            win       <= '0;
            drain_cnt <= 1'b0;
            px_ready  <= 1'b0;
            ofm_valid <= 1'b0;
            ofm_grp   <= '0;
            layer_end <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            tap       <= tap_n;
            grp       <= grp_n;
            win       <= win_n;
            drain_cnt <= drain_n;
            px_ready  <= (state_n == ST_ACC);
            layer_end <= (state_n == ST_DONE);
            busy      <= (state_n != ST_IDLE);
            if (load_out_c) begin
                ofm_valid <= 1'b1;
                ofm_grp   <= grp;
            end else if (ofm_valid && ofm_ready) begin
                ofm_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n    = state;
        tap_n      = tap;
        grp_n      = grp;
        win_n      = win;
        drain_n    = drain_cnt;
        load_out_c = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (layer_en) begin
                    state_n = ST_ACC;
                    tap_n   = '0;
                    grp_n   = '0;
                    win_n   = '0;
                end
            end
            ST_ACC: begin
                if (accept_c) begin
                    if (tap == TAP_W'(TAPS - 1)) begin
                        tap_n   = '0;
                        drain_n = 1'b0;
                        state_n = ST_DRAIN;
                    end else begin
                        tap_n = tap + TAP_W'(1);
                    end
                end
            end
            // Two cycles let the product and accumulator stages settle
            ST_DRAIN: begin
                if (drain_cnt) begin
                    load_out_c = 1'b1;
                    state_n    = ST_OUT;
                end else begin
                    drain_n = 1'b1;
                end
            end
            ST_OUT: begin
                if (ofm_valid && ofm_ready) begin
                    if (grp < GRP_W'(GROUPS - 1)) begin
                        grp_n   = grp + GRP_W'(1);
                        tap_n   = '0;
                        state_n = ST_ACC;
                    end else if (win < WIN_W'(NWIN - 1)) begin
                        grp_n   = '0;
                        win_n   = win + WIN_W'(1);
                        tap_n   = '0;
                        state_n = ST_ACC;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    for (genvar i = 0; i < DSP_NO; i++) begin : g_lane
        mac_lane #(
            .WIDTH  (WIDTH),
            .FRAC   (FRAC),
            .ACC_W  (ACC_W),
            .RELU_EN(RELU_EN)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .issue   (accept_c),
            .first   (first_c),
            .px      (px_data),
            .wt      (wt_data[i*WIDTH +: WIDTH]),
            .bias    (bias_data[i*WIDTH +: WIDTH]),
            .load_out(load_out_c),
            .result  (ofm_data[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench: two engines (ReLU on / off) with 4 lanes, 2 groups, 2 taps, 4 windows.
module tb_conv_mac_engine;

    logic        clk = 1'b0;
    logic        rst, layer_en, px_valid, ofm_ready;
    logic [15:0] px_data;

    logic        px_ready_a, px_ready_b, ofm_valid_a, ofm_valid_b;
    logic        layer_end_a, layer_end_b, busy_a, busy_b;
    logic [1:0]  wt_addr_a, wt_addr_b;
    logic [0:0]  bias_grp_a, bias_grp_b, ofm_grp_a, ofm_grp_b;
    logic [63:0] wt_data_a, wt_data_b, bias_data_a, bias_data_b, ofm_data_a, ofm_data_b;

    logic [63:0] wrom [4];
    logic [63:0] brom [2];
    logic [63:0] exp_r [4][2];
    logic [63:0] exp_l [4][2];
    logic [15:0] px0 [4];
    logic [15:0] px1 [4];

    int n_assert = 0;
    int n_fail   = 0;
    int beats    = 0;
    int le_cnt   = 0;

    always #5 clk = ~clk;

    assign wt_data_a   = wrom[wt_addr_a];
    assign wt_data_b   = wrom[wt_addr_b];
    assign bias_data_a = brom[bias_grp_a];
    assign bias_data_b = brom[bias_grp_b];

    conv_mac_engine #(.DSP_NO(4), .WIDTH(16), .FRAC(8), .KERNEL_DIM(1), .CHIN(2), .CHOUT(8),
                      .W_IN(2), .H_IN(2), .STRIDE(1), .PAD(0), .RELU_EN(1)) dut_a (
        .clk(clk), .rst(rst), .layer_en(layer_en), .px_data(px_data), .px_valid(px_valid),
        .px_ready(px_ready_a), .wt_addr(wt_addr_a), .wt_data(wt_data_a), .bias_data(bias_data_a),
        .bias_grp(bias_grp_a), .ofm_data(ofm_data_a), .ofm_valid(ofm_valid_a), .ofm_ready(ofm_ready),
        .ofm_grp(ofm_grp_a), .layer_end(layer_end_a), .busy(busy_a));

    conv_mac_engine #(.DSP_NO(4), .WIDTH(16), .FRAC(8), .KERNEL_DIM(1), .CHIN(2), .CHOUT(8),
                      .W_IN(2), .H_IN(2), .STRIDE(1), .PAD(0), .RELU_EN(0)) dut_b (
        .clk(clk), .rst(rst), .layer_en(layer_en), .px_data(px_data), .px_valid(px_valid),
        .px_ready(px_ready_b), .wt_addr(wt_addr_b), .wt_data(wt_data_b), .bias_data(bias_data_b),
        .bias_grp(bias_grp_b), .ofm_data(ofm_data_b), .ofm_valid(ofm_valid_b), .ofm_ready(ofm_ready),
        .ofm_grp(ofm_grp_b), .layer_end(layer_end_b), .busy(busy_b));

    // Handshake and layer-end pulse counters
    always @(posedge clk) begin
        if (ofm_valid_a && ofm_ready) beats <= beats + 1;
        if (layer_end_a) le_cnt <= le_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_px(input logic [15:0] d, input logic [1:0] addr, input int gap);
        int guard;
        px_valid = 1'b0;
        repeat (gap) @(negedge clk);
        px_data  = d;
        px_valid = 1'b1;
        guard    = 0;
        while (!px_ready_a && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("px_ready", 64'(px_ready_a), 64'd1);
        check("wt_addr", 64'(wt_addr_a), 64'(addr));
        @(negedge clk);
        px_valid = 1'b0;
    endtask

    task automatic run_layer(input bit gaps, input int stall_beat, input int abort_win, input bit hold);
        int beat;
        int lat;
        beat     = 0;
        layer_en = 1'b1;
        @(negedge clk);
        if (!hold) layer_en = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int g = 0; g < 2; g++) begin
                send_px(px0[w], 2'(g * 2), gaps ? int'($urandom_range(0, 3)) : 0);
                if (w == abort_win) return;
                send_px(px1[w], 2'(g * 2 + 1), gaps ? int'($urandom_range(0, 3)) : 0);
                lat = 1;
                while (!ofm_valid_a && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                check("latency", 64'(lat), 64'd3);
                check("ofm_relu", ofm_data_a, exp_r[w][g]);
                check("ofm_lin", ofm_data_b, exp_l[w][g]);
                check("ofm_grp", 64'(ofm_grp_a), 64'(g));
                if (beat == stall_beat) begin
                    repeat (5) begin
                        @(negedge clk);
                        check("stall_data", ofm_data_a, exp_r[w][g]);
                        check("stall_valid", 64'(ofm_valid_a), 64'd1);
                        check("stall_px_ready", 64'(px_ready_a), 64'd0);
                    end
                end
                check("out_px_ready", 64'(px_ready_a), 64'd0);
                ofm_ready = 1'b1;
                @(negedge clk);
                ofm_ready = 1'b0;
                check("valid_drop", 64'(ofm_valid_a), 64'd0);
                beat++;
            end
        end
        check("layer_end", 64'({layer_end_a, layer_end_b}), 64'd3);
        check("busy_done", 64'(busy_a), 64'd1);
        @(negedge clk);
        check("layer_end_drop", 64'(layer_end_a), 64'd0);
        check("busy_idle", 64'(busy_a), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int l0;
        wrom[0] = 64'h8100_7F00_0100_0100;
        wrom[1] = 64'h8100_7F00_0080_0100;
        wrom[2] = 64'hFFFF_0001_0040_0200;
        wrom[3] = 64'h0000_0000_0040_FF00;
        brom[0] = 64'h0000_0000_FE00_0000;
        brom[1] = 64'h0000_0000_0000_0080;
        px0[0] = 16'h0100; px1[0] = 16'h0200;
        px0[1] = 16'h0100; px1[1] = 16'h0100;
        px0[2] = 16'h7F00; px1[2] = 16'h7F00;
        px0[3] = 16'hFF00; px1[3] = 16'h0080;
        exp_r[0][0] = 64'h0000_7FFF_0000_0300; exp_l[0][0] = 64'h8000_7FFF_0000_0300;
        exp_r[0][1] = 64'h0000_0001_00C0_0080; exp_l[0][1] = 64'hFFFF_0001_00C0_0080;
        exp_r[1][0] = 64'h0000_7FFF_0000_0200; exp_l[1][0] = 64'h8000_7FFF_FF80_0200;
        exp_r[1][1] = 64'h0000_0001_0080_0180; exp_l[1][1] = 64'hFFFF_0001_0080_0180;
        exp_r[2][0] = 64'h0000_7FFF_7FFF_7FFF; exp_l[2][0] = 64'h8000_7FFF_7FFF_7FFF;
        exp_r[2][1] = 64'h0000_007F_3F80_7F80; exp_l[2][1] = 64'hFF81_007F_3F80_7F80;
        exp_r[3][0] = 64'h3F80_0000_0000_0000; exp_l[3][0] = 64'h3F80_C080_FD40_FF80;
        exp_r[3][1] = 64'h0001_0000_0000_0000; exp_l[3][1] = 64'h0001_FFFF_FFE0_FE00;

        rst = 1'b1; layer_en = 1'b0; px_valid = 1'b0; px_data = '0; ofm_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({px_ready_a, ofm_valid_a, layer_end_a, busy_a}), 64'd0);
        check("rst_data", ofm_data_a | ofm_data_b, 64'd0);
        check("rst_addr", 64'({wt_addr_a, bias_grp_a, ofm_grp_a}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy_a), 64'd0);

        // Gap-free layer
        b0 = beats; l0 = le_cnt;
        run_layer(1'b0, -1, -1, 1'b0);
        check("beats_clean", 64'(beats - b0), 64'd8);
        check("le_pulses", 64'(le_cnt - l0), 64'd1);

        // Random pixel gaps plus a 5-cycle output stall
        b0 = beats;
        run_layer(1'b1, 5, -1, 1'b0);
        check("beats_gaps", 64'(beats - b0), 64'd8);

        // Abort in the second window, then restart
        b0 = beats;
        run_layer(1'b0, -1, 1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ctrl", 64'({px_ready_a, ofm_valid_a, layer_end_a, busy_a}), 64'd0);
        check("abort_data", ofm_data_a | ofm_data_b, 64'd0);
        check("abort_addr", 64'({wt_addr_a, bias_grp_a, ofm_grp_a}), 64'd0);
        repeat (4) @(negedge clk);
        check("abort_no_beat", 64'({ofm_valid_a, ofm_valid_b}), 64'd0);
        check("abort_beats", 64'(beats - b0), 64'd2);
        b0 = beats;
        run_layer(1'b0, -1, -1, 1'b0);
        check("beats_restart", 64'(beats - b0), 64'd8);

        // layer_en held high: ignored mid-layer, restart after one IDLE cycle
        b0 = beats; l0 = le_cnt;
        run_layer(1'b0, -1, -1, 1'b1);
        check("beats_hold", 64'(beats - b0), 64'd8);
        check("le_hold", 64'(le_cnt - l0), 64'd1);
        @(negedge clk);
        check("hold_restart", 64'(busy_a), 64'd1);
        layer_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("final_rst", 64'({busy_a, px_ready_a}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
